// File: rtl/ingress_wr_engine_pkg.sv
// Shared constants, descriptor and FSM types for the ingress write engine.
package ingress_pkg;

    localparam logic [47:0] FEP_HEADER   = 48'h1EADFEB5AC0D;
    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ETYPE_IPV6   = 16'h86DD;
    localparam int unsigned IPV4_LEN_OFS = 18;
    localparam int unsigned IPV6_LEN_OFS = 58;
    localparam int unsigned MIN_LEN      = 63;
    localparam int unsigned MAX_LEN      = 1519;

    typedef struct packed {
        logic [7:0] beats;
    } desc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } wr_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ingress_wr_engine_if.sv
// MAC stream and AXI4 write-channel bundles.
interface ingress_axis_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

interface ingress_axi_if #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ingress_wr_engine_sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    assign dout  = mem[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q + (AW+1)'(push && !full);
        rd_d = rd_q + (AW+1)'(pop && !empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !rst) mem[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ingress_wr_engine.sv
// Header-checks MAC frames, buffers them per packet and drains committed
// packets into a DDR ring as 4 KiB-safe AXI4 INCR bursts.
module ingress_wr_engine
    import ingress_pkg::*;
#(
    parameter int              ADDR_WIDTH   = 31,
    parameter int              DATA_WIDTH   = 512,
    parameter int              ID_WIDTH     = 4,
    parameter int              BUFFER_DEPTH = 4096,
    parameter int              DESC_DEPTH   = 16,
    parameter longint unsigned DDR_BASE     = 0,
    parameter longint unsigned DDR_SIZE     = 2**30
) (
    input  logic                  clk,
    input  logic                  rst,
    ingress_axis_if.slave         s_axis,
    ingress_axi_if.master         m_axi,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_hdr_cnt,
    output logic [31:0]           drop_ovf_cnt,
    output logic [31:0]           bresp_err_cnt,
    output logic [ADDR_WIDTH-1:0] ddr_wr_ptr
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int BUF_BEATS  = BUFFER_DEPTH / BEAT_BYTES;
    localparam int BAW        = $clog2(BUF_BEATS);
    localparam int AW1        = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0]        RING_END = AW1'(DDR_BASE + DDR_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(DDR_BASE);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_BEATS];
    logic [BAW:0]  sh_ptr_q, sh_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          busy_q, busy_d, drop_q, drop_d;
    logic [7:0]    pkt_beats_q, pkt_beats_d;
    logic [31:0]   pkt_q, pkt_d, hdr_q, hdr_d, ovf_q, ovf_d, berr_q, berr_d;
    logic          buf_we, buf_full;
    logic [DATA_WIDTH-1:0] buf_wdata, first_beat;

    logic [15:0]   etype, len_fld, l_len;
    logic [16:0]   frame_len;
    logic          is_v6, hdr_ok;
    logic [7:0]    hdr_beats;

    desc_t         desc_in, desc_out;
    logic          desc_push, desc_pop, desc_full, desc_empty;

    wr_state_e     state_q, state_d;
    logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d;
    logic          pf_valid_q, pf_valid_d, pf_load;
    logic [7:0]    rem_q, rem_d, burst_q, burst_d, beat_q, beat_d, aw_beats;
    logic [ADDR_WIDTH-1:0] ddr_q, ddr_d;
    logic [AW1-1:0] ddr_next;
    logic [12:0]   bnd_beats;
    logic          w_valid, w_last, w_fire;

    always_comb begin
        etype     = {s_axis.tdata[96 +: 8], s_axis.tdata[104 +: 8]};
        is_v6     = (etype == ETYPE_IPV6);
        len_fld   = is_v6 ? {s_axis.tdata[144 +: 8], s_axis.tdata[152 +: 8]}
                          : {s_axis.tdata[128 +: 8], s_axis.tdata[136 +: 8]};
        frame_len = {1'b0, len_fld}
                  + (is_v6 ? 17'(IPV6_LEN_OFS) : 17'(IPV4_LEN_OFS));
        hdr_ok    = (is_v6 || etype == ETYPE_IPV4)
                  && frame_len > 17'(MIN_LEN) && frame_len < 17'(MAX_LEN);
        l_len     = 16'(frame_len - 17'd4);
        hdr_beats = 8'((l_len + 16'(BEAT_BYTES - 1)) >> BEAT_SHIFT);
        first_beat = s_axis.tdata;
        first_beat[95:0] = {FEP_HEADER, l_len, l_len, l_len};
    end

    assign buf_full = (sh_ptr_q - rd_ptr_q) == (BAW+1)'(BUF_BEATS);

    // Beats land at the shadow pointer; wr_ptr only moves on a clean commit.
    always_comb begin
        sh_ptr_d    = sh_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        busy_d      = busy_q;
        drop_d      = drop_q;
        pkt_beats_d = pkt_beats_q;
        pkt_d       = pkt_q;
        hdr_d       = hdr_q;
        ovf_d       = ovf_q;
        buf_we      = 1'b0;
        buf_wdata   = s_axis.tdata;
        desc_push   = 1'b0;
        desc_in     = '{beats: busy_q ? pkt_beats_q : hdr_beats};
        if (s_axis.tvalid) begin
            busy_d = !s_axis.tlast;
            if (!busy_q) begin
                drop_d = 1'b1;
                if (!hdr_ok) begin
                    hdr_d = sat_inc(hdr_q);
                end else if (buf_full) begin
                    ovf_d = sat_inc(ovf_q);
                end else begin
                    drop_d      = 1'b0;
                    buf_we      = 1'b1;
                    buf_wdata   = first_beat;
                    pkt_beats_d = hdr_beats;
                end
            end else if (!drop_q) begin
                if (buf_full) begin
                    drop_d   = 1'b1;
                    ovf_d    = sat_inc(ovf_q);
                    sh_ptr_d = wr_ptr_q;
                end else begin
                    buf_we = 1'b1;
                end
            end
            if (buf_we) begin
                sh_ptr_d = sh_ptr_q + 1'b1;
                if (s_axis.tlast) begin
                    if (desc_full) begin
                        sh_ptr_d = wr_ptr_q;
                        ovf_d    = sat_inc(ovf_q);
                    end else begin
                        desc_push = 1'b1;
                        wr_ptr_d  = sh_ptr_q + 1'b1;
                        pkt_d     = sat_inc(pkt_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we && !rst) buf_mem[sh_ptr_q[BAW-1:0]] <= buf_wdata;
    end

    sync_fifo #(
        .WIDTH ($bits(desc_t)),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (desc_push),
        .din   (desc_in),
        .pop   (desc_pop),
        .dout  (desc_out),
        .full  (desc_full),
        .empty (desc_empty)
    );

    // One-entry prefetch keeps W at full rate from committed data.
    always_comb begin
        w_valid    = (state_q == S_DATA) && pf_valid_q;
        w_last     = w_valid && (beat_q == burst_q - 8'd1);
        w_fire     = w_valid && m_axi.wready;
        pf_load    = (rd_ptr_q != wr_ptr_q) && (!pf_valid_q || w_fire);
        pf_valid_d = pf_load || (pf_valid_q && !w_fire);
        pf_data_d  = pf_load ? buf_mem[rd_ptr_q[BAW-1:0]] : pf_data_q;
        rd_ptr_d   = rd_ptr_q + (BAW+1)'(pf_load);
        bnd_beats  = (13'h1000 - {1'b0, ddr_q[11:0]}) >> BEAT_SHIFT;
        aw_beats   = ({5'b0, rem_q} < bnd_beats) ? rem_q : bnd_beats[7:0];
        ddr_next   = {1'b0, ddr_q} + (AW1'(burst_q) << BEAT_SHIFT);
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        ddr_d    = ddr_q;
        desc_pop = 1'b0;
        berr_d   = (m_axi.bvalid && m_axi.bresp != 2'b00) ? sat_inc(berr_q) : berr_q;
        unique case (1'b1)
            state_q == S_IDLE: if (!desc_empty) begin
                desc_pop = 1'b1;
                rem_d    = desc_out.beats;
                state_d  = S_ADDR;
            end
            state_q == S_ADDR: if (m_axi.awready) begin
                burst_d = aw_beats;
                beat_d  = '0;
                state_d = S_DATA;
            end
            state_q == S_DATA: if (w_fire) begin
                beat_d = beat_q + 8'd1;
                if (w_last) begin
                    rem_d   = rem_q - burst_q;
                    ddr_d   = (ddr_next == RING_END) ? BASE : ddr_next[ADDR_WIDTH-1:0];
                    state_d = (rem_q != burst_q) ? S_ADDR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE; sh_ptr_q <= '0; wr_ptr_q <= '0; rd_ptr_q <= '0;
            busy_q <= 1'b0; drop_q <= 1'b0; pkt_beats_q <= '0;
            pkt_q <= '0; hdr_q <= '0; ovf_q <= '0; berr_q <= '0;
            pf_valid_q <= 1'b0; pf_data_q <= '0;
            rem_q <= '0; burst_q <= '0; beat_q <= '0; ddr_q <= BASE;
        end else begin
            state_q <= state_d; sh_ptr_q <= sh_ptr_d; wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d;
            busy_q <= busy_d; drop_q <= drop_d; pkt_beats_q <= pkt_beats_d;
            pkt_q <= pkt_d; hdr_q <= hdr_d; ovf_q <= ovf_d; berr_q <= berr_d;
            pf_valid_q <= pf_valid_d; pf_data_q <= pf_data_d;
            rem_q <= rem_d; burst_q <= burst_d; beat_q <= beat_d; ddr_q <= ddr_d;
        end
    end

    assign s_axis.tready = 1'b1;
    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = ddr_q;
    assign m_axi.awlen   = aw_beats - 8'd1;
    assign m_axi.awsize  = 3'(BEAT_SHIFT);
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = (state_q == S_ADDR);
    assign m_axi.wdata   = pf_data_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = w_last;
    assign m_axi.wvalid  = w_valid;
    assign m_axi.bready  = 1'b1;

    assign pkt_cnt       = pkt_q;
    assign drop_hdr_cnt  = hdr_q;
    assign drop_ovf_cnt  = ovf_q;
    assign bresp_err_cnt = berr_q;
    assign ddr_wr_ptr    = ddr_q;
endmodule

// File: tb/tb_ingress_wr_engine.sv
// Directed bench for ingress_wr_engine on an 8 KiB ring at address 0.
module tb_ingress_wr_engine;
    localparam int DW = 512;
    localparam int AW = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ingress_axis_if #(.DATA_WIDTH(DW)) s_axis ();
    ingress_axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(4)) m_axi ();

    logic [31:0]   pkt_cnt, drop_hdr_cnt, drop_ovf_cnt, bresp_err_cnt;
    logic [AW-1:0] ddr_wr_ptr;

    ingress_wr_engine #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DDR_BASE   (0),
        .DDR_SIZE   (8192)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis        (s_axis),
        .m_axi         (m_axi),
        .pkt_cnt       (pkt_cnt),
        .drop_hdr_cnt  (drop_hdr_cnt),
        .drop_ovf_cnt  (drop_ovf_cnt),
        .bresp_err_cnt (bresp_err_cnt),
        .ddr_wr_ptr    (ddr_wr_ptr)
    );

    int checks = 0;
    int errors = 0;
    int n_wlast = 0;
    logic [AW-1:0] aw_addr_q [$];
    logic [7:0]    aw_len_q [$];
    logic [DW-1:0] w_data_q [$];
    logic [DW-1:0] exp_w [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (m_axi.awvalid && m_axi.awready) begin
                aw_addr_q.push_back(m_axi.awaddr);
                aw_len_q.push_back(m_axi.awlen);
            end
            if (m_axi.wvalid && m_axi.wready) begin
                w_data_q.push_back(m_axi.wdata);
                if (m_axi.wlast) n_wlast++;
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_beat(input int seed, input int idx);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = 32'(seed * 65536 + idx * 256 + k);
        return d;
    endfunction

    task automatic send_pkt(input logic [15:0] et, input logic [15:0] lenf,
                            input int nb, input bit ok, input int seed);
        logic [DW-1:0] d, e;
        logic [15:0] l;
        l = lenf + ((et == 16'h86DD) ? 16'd58 : 16'd18) - 16'd4;
        for (int i = 0; i < nb; i++) begin
            d = mk_beat(seed, i);
            if (i == 0) begin
                d[96 +: 8]  = et[15:8];
                d[104 +: 8] = et[7:0];
                if (et == 16'h86DD) begin
                    d[144 +: 8] = lenf[15:8];
                    d[152 +: 8] = lenf[7:0];
                end else begin
                    d[128 +: 8] = lenf[15:8];
                    d[136 +: 8] = lenf[7:0];
                end
            end
            s_axis.tdata  = d;
            s_axis.tvalid = 1'b1;
            s_axis.tlast  = (i == nb - 1);
            if (ok) begin
                e = d;
                if (i == 0) e[95:0] = {48'h1EADFEB5AC0D, l, l, l};
                exp_w.push_back(e);
            end
            @(posedge clk); #1;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic wait_w(input int n, input string tag);
        int t = 0;
        while (w_data_q.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_wcount"}, DW'(w_data_q.size()), DW'(n));
    endtask

    task automatic chk_w(input string tag);
        int i = 0;
        chk({tag, "_explen"}, DW'(w_data_q.size()), DW'(exp_w.size()));
        while (w_data_q.size() > 0 && exp_w.size() > 0) begin
            chk($sformatf("%s_beat%0d", tag, i), w_data_q.pop_front(), exp_w.pop_front());
            i++;
        end
        w_data_q.delete();
        exp_w.delete();
    endtask

    task automatic chk_aw(input string tag, input logic [AW-1:0] a, input logic [7:0] l);
        logic [AW-1:0] oa = 'x;
        logic [7:0]    ol = 'x;
        if (aw_addr_q.size() > 0) begin
            oa = aw_addr_q.pop_front();
            ol = aw_len_q.pop_front();
        end
        chk({tag, "_awaddr"}, DW'(oa), DW'(a));
        chk({tag, "_awlen"}, DW'(ol), DW'(l));
    endtask

    initial begin
        int t;
        s_axis.tdata  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axi.awready = 1'b1;
        m_axi.wready  = 1'b1;
        m_axi.bvalid  = 1'b0;
        m_axi.bresp   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", DW'(m_axi.awvalid), DW'(0));
        chk("rst_wvalid", DW'(m_axi.wvalid), DW'(0));
        chk("rst_wlast", DW'(m_axi.wlast), DW'(0));
        chk("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        chk("rst_hdr_cnt", DW'(drop_hdr_cnt), DW'(0));
        chk("rst_ovf_cnt", DW'(drop_ovf_cnt), DW'(0));
        chk("rst_berr_cnt", DW'(bresp_err_cnt), DW'(0));
        chk("rst_ddr_ptr", DW'(ddr_wr_ptr), DW'(0));
        chk("tready", DW'(s_axis.tready), DW'(1));
        chk("wstrb", DW'(m_axi.wstrb), {{(DW - 64){1'b0}}, {64{1'b1}}});
        rst = 1'b0;
        @(posedge clk); #1;

        // minimum IPv4 frame: L = 60, one beat
        send_pkt(16'h0800, 16'h002E, 1, 1'b1, 1);
        wait_w(1, "v4min");
        chk_aw("v4min", 31'h0, 8'd0);
        chk("v4min_hdr", DW'(w_data_q[0][95:0]), DW'(96'h1EADFEB5AC0D_003C_003C_003C));
        chk_w("v4min");
        chk("v4min_pkt_cnt", DW'(pkt_cnt), DW'(1));
        chk("v4min_ptr", DW'(ddr_wr_ptr), DW'(31'h40));

        // ARP, length 63 and 1519 are rejected; only the last packet lands
        send_pkt(16'h0806, 16'h002E, 2, 1'b0, 2);
        send_pkt(16'h0800, 16'h002D, 1, 1'b0, 4);
        send_pkt(16'h86DD, 16'd1461, 1, 1'b0, 5);
        send_pkt(16'h0800, 16'h002E, 1, 1'b1, 3);
        wait_w(1, "hdrdrop");
        chk("hdrdrop_cnt", DW'(drop_hdr_cnt), DW'(3));
        chk("hdrdrop_pkt_cnt", DW'(pkt_cnt), DW'(2));
        chk_aw("hdrdrop", 31'h40, 8'd0);
        chk_w("hdrdrop");
        chk("hdrdrop_ptr", DW'(ddr_wr_ptr), DW'(31'h80));

        // three 1518-byte frames with W stalled: third overflows
        m_axi.wready = 1'b0;
        send_pkt(16'h0800, 16'h05DC, 24, 1'b1, 10);
        send_pkt(16'h0800, 16'h05DC, 24, 1'b1, 11);
        send_pkt(16'h0800, 16'h05DC, 24, 1'b0, 12);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_cnt", DW'(drop_ovf_cnt), DW'(1));
        chk("ovf_pkt_cnt", DW'(pkt_cnt), DW'(4));
        m_axi.wready = 1'b1;
        wait_w(48, "ovf");
        chk_aw("ovf_p1", 31'h080, 8'd23);
        chk_aw("ovf_p2", 31'h680, 8'd23);
        chk_w("ovf");
        chk("ovf_ptr", DW'(ddr_wr_ptr), DW'(31'hC80));

        // L = 800, 13 beats, brings the pointer to 0xFC0
        send_pkt(16'h0800, 16'h0312, 13, 1'b1, 13);
        wait_w(13, "l800");
        chk_aw("l800", 31'hC80, 8'd12);
        chk_w("l800");
        chk("l800_ptr", DW'(ddr_wr_ptr), DW'(31'hFC0));

        // IPv6 payload 1200: L = 1254, 20 beats split at 0x1000
        send_pkt(16'h86DD, 16'd1200, 20, 1'b1, 20);
        wait_w(20, "v6split");
        chk_aw("v6split_b1", 31'hFC0, 8'd0);
        chk_aw("v6split_b2", 31'h1000, 8'd18);
        chk_w("v6split");
        chk("v6split_ptr", DW'(ddr_wr_ptr), DW'(31'h14C0));

        // fill to the last beat of the ring
        send_pkt(16'h0800, 16'h05DC, 24, 1'b1, 21);
        send_pkt(16'h0800, 16'd1266, 20, 1'b1, 22);
        wait_w(44, "fill");
        chk_aw("fill_p1", 31'h14C0, 8'd23);
        chk_aw("fill_p2", 31'h1AC0, 8'd19);
        chk_w("fill");
        chk("fill_ptr", DW'(ddr_wr_ptr), DW'(31'h1FC0));

        // 2-beat packet wraps: last beat of ring, then base
        send_pkt(16'h0800, 16'd100, 2, 1'b1, 23);
        wait_w(2, "wrap");
        chk_aw("wrap_b1", 31'h1FC0, 8'd0);
        chk_aw("wrap_b2", 31'h0, 8'd0);
        chk_w("wrap");
        chk("wrap_ptr", DW'(ddr_wr_ptr), DW'(31'h40));
        chk("wrap_extra_aw", DW'(aw_addr_q.size()), DW'(0));
        chk("wlast_count", DW'(n_wlast), DW'(11));

        // error and okay write responses
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = 2'b10;
        @(posedge clk); #1;
        m_axi.bresp  = 2'b00;
        @(posedge clk); #1;
        m_axi.bvalid = 1'b0;
        chk("bresp_err_cnt", DW'(bresp_err_cnt), DW'(1));

        // reset while AW is pending
        m_axi.awready = 1'b0;
        send_pkt(16'h0800, 16'h002E, 1, 1'b0, 30);
        t = 0;
        while (!m_axi.awvalid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("midrst_awvalid_hi", DW'(m_axi.awvalid), DW'(1));
        chk("awsize", DW'(m_axi.awsize), DW'(6));
        chk("awburst", DW'(m_axi.awburst), DW'(1));
        chk("awid", DW'(m_axi.awid), DW'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_awvalid", DW'(m_axi.awvalid), DW'(0));
        chk("midrst_wvalid", DW'(m_axi.wvalid), DW'(0));
        chk("midrst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        chk("midrst_hdr_cnt", DW'(drop_hdr_cnt), DW'(0));
        chk("midrst_ovf_cnt", DW'(drop_ovf_cnt), DW'(0));
        chk("midrst_berr_cnt", DW'(bresp_err_cnt), DW'(0));
        chk("midrst_ptr", DW'(ddr_wr_ptr), DW'(0));
        rst = 1'b0;
        m_axi.awready = 1'b1;
        aw_addr_q.delete();
        aw_len_q.delete();
        w_data_q.delete();
        exp_w.delete();
        @(posedge clk); #1;
        send_pkt(16'h0800, 16'h002E, 1, 1'b1, 31);
        wait_w(1, "postrst");
        chk_aw("postrst", 31'h0, 8'd0);
        chk_w("postrst");
        chk("postrst_pkt_cnt", DW'(pkt_cnt), DW'(1));
        chk("wlast_total", DW'(n_wlast), DW'(12));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ingress_wr_engine.md
INGRESS_WR_ENGINE -- requirements
Module: ingress_wr_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 31, DDR byte address width.
- DATA_WIDTH, 512, stream and AXI data width (multiple of 128).
- ID_WIDTH, 4, AXI ID width.
- BUFFER_DEPTH, 4096, packet buffer size in bytes.
- DESC_DEPTH, 16, committed-packet descriptor FIFO entries.
- DDR_BASE, 0, ring start (4 KiB aligned).
- DDR_SIZE, 2**30, ring size in bytes (multiple of 4 KiB).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- s_axis_tdata / tvalid / tlast, in, DATA_WIDTH/1/1, MAC stream.
- s_axis_tready, out, 1, constant 1.
- m_axi_awid / awaddr / awlen / awsize / awburst / awvalid, out, ID_WIDTH/ADDR_WIDTH/8/3/2/1, AXI4 write address.
- m_axi_awready, in, 1.
- m_axi_wdata / wstrb / wlast / wvalid, out, DATA_WIDTH/DATA_WIDTH/8/1/1, AXI4 write data.
- m_axi_wready, in, 1.
- m_axi_bresp / bvalid, in, 2/1; m_axi_bready, out, 1, constant 1.
- pkt_cnt, drop_hdr_cnt, drop_ovf_cnt, bresp_err_cnt, out, 32 each, saturating status counters.
- ddr_wr_ptr, out, ADDR_WIDTH, address of the next burst.

Function
REQ-003 The first beat SHALL pass the header check when EtherType (bytes 12-13, big-endian) = 0x0800 with length bytes 16-17 + 18 in the open range (63, 1519), or EtherType = 0x86DD with length bytes 18-19 + 58 in (63, 1519).
REQ-004 A passing first beat SHALL be stored with bytes 0-11 replaced by {48'h1EADFEB5AC0D, L, L, L}, where L = computed length - 4 and L occupies bits [15:0].
REQ-005 A failing packet SHALL be discarded through tlast, and drop_hdr_cnt SHALL increment once.
REQ-006 Packet writes SHALL be tentative (shadow write pointer) and SHALL commit only on tlast, when the descriptor FIFO is not full; commit SHALL push beats = ceil(L / BEAT_BYTES) and increment pkt_cnt.
REQ-007 Buffer full during a packet, or descriptor FIFO full at tlast, SHALL roll the shadow pointer back, discard the remaining beats through tlast, and increment drop_ovf_cnt once; committed packets SHALL be unaffected.
REQ-008 A single-beat packet (tvalid with tlast on the first beat) SHALL be handled as both first and last beat.
REQ-009 The write FSM SHALL have states IDLE, ADDR, DATA, with transitions:
- IDLE -> ADDR when a descriptor is available.
- ADDR -> DATA on awvalid & awready.
- DATA -> ADDR on the final accepted wlast beat when a split remains.
- DATA -> IDLE on the final accepted wlast beat otherwise.
REQ-010 Fixed AXI fields SHALL be awsize = log2(BEAT_BYTES), awburst = INCR, awid = 0, wstrb all ones.
REQ-011 A burst crossing a 4 KiB boundary SHALL be split into two bursts at that boundary; awlen SHALL equal the burst beats minus 1.
REQ-012 The address after DDR_BASE + DDR_SIZE - BEAT_BYTES SHALL wrap to DDR_BASE; because the ring is 4 KiB aligned, no burst spans the wrap.
REQ-013 wvalid SHALL assert only in DATA and SHALL hold wdata stable until wready; wlast SHALL accompany the final beat of each burst.
REQ-014 awvalid SHALL hold stable until awready; at most one AW SHALL be outstanding before its W beats complete.
REQ-015 Buffer read SHALL be prefetched so that W sustains one beat per cycle while wready is high.
REQ-016 bresp != OKAY on bvalid SHALL increment bresp_err_cnt.
REQ-017 ddr_wr_ptr SHALL advance by burst beats x BEAT_BYTES on each burst's final accepted beat.

Reset
REQ-018 On rst:
- All counters SHALL clear to 0.
- ddr_wr_ptr SHALL be set to DDR_BASE.
- Buffer and descriptor pointers SHALL be emptied.
- The FSM SHALL return to IDLE.
- awvalid, wvalid and wlast SHALL be 0.
REQ-019 Reset asserted mid-burst or mid-packet SHALL abandon all in-flight data, with no further AXI valid asserted in the cycle after rst is sampled.
REQ-020 After reset release, the first beat seen SHALL be treated as a packet start.

Structure
REQ-021 Package ingress_pkg SHALL hold FEP_HEADER, the EtherType constants, the length offsets, the MIN/MAX length bounds, the descriptor struct and the FSM state enum.
REQ-022 The descriptor FIFO SHALL be sub-module sync_fifo (parameters WIDTH and DEPTH, with full/empty outputs).

Verification
REQ-023 IPv4 packet, length field 0x002E (L = 60, 1 beat) -> one AW at DDR_BASE with awlen 0; wdata[95:0] = {1EADFEB5AC0D, 003C, 003C, 003C}; pkt_cnt = 1.
REQ-024 IPv6 packet, length field 1200 (L = 1254, 20 beats) with the start address 0xFC0 -> burst 1 at 0xFC0 with awlen 0, burst 2 at 0x1000 with awlen 18.
REQ-025 EtherType 0x0806 packet followed by a valid IPv4 packet -> drop_hdr_cnt = 1; only the second packet is written.
REQ-026 wready held low with 3 back-to-back 1518-byte packets on a 4096-byte buffer -> the third packet is dropped, drop_ovf_cnt = 1, and the first two are written intact after wready rises.
REQ-027 ddr_wr_ptr = DDR_BASE + DDR_SIZE - 64 with a 2-beat packet -> one beat at the end address, next burst at DDR_BASE.
REQ-028 rst asserted with awvalid high mid-burst -> awvalid = 0 next cycle, counters 0, and the next packet is written at DDR_BASE.
